bus_rx_deser: RTL and testbench

- Receive end of the single-wire shared tristate serial bus; the transmit side drives the line through a non-inverting tristate buffer, and the line idles high with a pull-up.
- Synchronises the line, detects the start bit and shifts in an LSB-first payload.
- Checks even parity and the stop bit, then presents the word through a valid/ready handshake to the local FSM.
- Sits between the bus pad and the consumer logic.

---
 rtl/bus_rx_deser.sv | 172 +++++++++++++++++
 tb/tb_bus_rx_deser.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rx_deser.sv
// Receive side of the single-wire pulled-up serial bus: synchronise, find the
// start bit, shift in an LSB-first word, check parity/stop, hand off via valid/ready.
module bus_rx_deser #(
  parameter int DW     = 8,
  parameter int CPB    = 4,
  parameter int PAR_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bus_in,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          par_err,
  output logic          frm_err,
  output logic          ovr_err,
  output logic          busy
);

  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IW = $clog2(DW + 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   shreg;
  logic            pacc;
  logic            perr;
  logic            deliver;
  logic            sync1, bus_s, bus_d;
  logic            bus_c;
  logic [DW:0]     sh_next;

  // A floating or unknown line reads as idle (the pull-up wins).
  assign bus_c   = (bus_in !== 1'b0);
  assign sh_next = {bus_s, shreg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      bus_s <= 1'b1;
      bus_d <= 1'b1;
    end else begin
      sync1 <= bus_c;
      bus_s <= sync1;
      bus_d <= bus_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      pacc    <= 1'b0;
      perr    <= 1'b0;
      deliver <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      par_err <= 1'b0;
      frm_err <= 1'b0;
      deliver <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus_d && !bus_s) begin
            state <= S_START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!bus_s) begin
              state <= S_DATA;
              idx   <= '0;
              pacc  <= 1'b0;
              perr  <= 1'b0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= sh_next[DW:1];
            pacc  <= pacc ^ bus_s;
            if (idx == IDX_LAST) begin
              state <= (PAR_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            perr  <= pacc ^ bus_s;
            state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            // A low stop bit is a framing error regardless of parity.
            if (!bus_s) begin
              frm_err <= 1'b1;
              state   <= S_WAIT_HI;
            end else begin
              if (perr) par_err <= 1'b1;
              else      deliver <= 1'b1;
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_HI: begin
          if (bus_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: a consume in the delivery cycle frees the slot for the new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      ovr_err <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          ovr_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_rx_deser.sv
// Directed bench for bus_rx_deser: good frames, parity/framing/overrun errors,
// handshake corner cases, glitches and asynchronous reset mid-frame.
module tb_bus_rx_deser;
  localparam int DW = 8, CPB = 4, PAR_EN = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bus_in = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid, par_err, frm_err, ovr_err, busy;

  int errors = 0;
  int checks = 0;

  bus_rx_deser #(.DW(DW), .CPB(CPB), .PAR_EN(PAR_EN)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .par_err(par_err),
    .frm_err(frm_err), .ovr_err(ovr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts pulses, valid rises/drops and accepted words.
  int            par_cnt = 0, frm_cnt = 0, ovr_cnt = 0, rise_cnt = 0, drop_cnt = 0;
  int            rise_cyc = 0;
  logic [DW-1:0] rise_data = '0;
  logic          prev_v = 1'b0;
  logic [DW-1:0] acc_q[$];

  always @(negedge clk) begin
    if (par_err) par_cnt++;
    if (frm_err) frm_cnt++;
    if (ovr_err) ovr_cnt++;
    if (rx_valid && !prev_v) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_data = rx_data;
    end
    if (prev_v && !rx_valid) drop_cnt++;
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    prev_v = rx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus_in = b;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                            output int t0);
    t0 = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h want 0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", rx_valid); end
    checks++; if ({par_err, frm_err, ovr_err} !== 3'b000) begin errors++; $display("FAIL reset_errs: got %b want 000", {par_err, frm_err, ovr_err}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_good_frame();
    int t0, p0, f0, o0, r0;
    p0 = par_cnt; f0 = frm_cnt; o0 = ovr_cnt; r0 = rise_cnt;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, t0);
    bus_in = 1'b1;
    repeat (10) tick();
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL good_rises: got %0d want 1", rise_cnt - r0); end
    checks++; if (rise_cyc - t0 !== 45) begin errors++; $display("FAIL good_latency: got %0d want 45", rise_cyc - t0); end
    checks++; if (rise_data !== 8'hA5) begin errors++; $display("FAIL good_data: got %0h want a5", rise_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL good_consumed: got %0b want 0", rx_valid); end
    checks++; if ((par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0) !== 0) begin errors++; $display("FAIL good_errs: got %0d want 0", (par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy: got %0b want 0", busy); end
  endtask

  task automatic test_parity();
    int t0, p0, f0, r0;
    p0 = par_cnt; f0 = frm_cnt; r0 = rise_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, t0);
    bus_in = 1'b1;
    repeat (10) tick();
    checks++; if (par_cnt - p0 !== 1) begin errors++; $display("FAIL par_pulse: got %0d want 1", par_cnt - p0); end
    checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL par_novalid: got %0d want 0", rise_cnt - r0); end
    checks++; if (frm_cnt - f0 !== 0) begin errors++; $display("FAIL par_nofrm: got %0d want 0", frm_cnt - f0); end
    p0 = par_cnt; r0 = rise_cnt;
    send_frame(8'h01, 1'b1, 1'b1, t0);
    bus_in = 1'b1;
    repeat (10) tick();
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL par_next_rise: got %0d want 1", rise_cnt - r0); end
    checks++; if (rise_data !== 8'h01) begin errors++; $display("FAIL par_next_data: got %0h want 01", rise_data); end
    checks++; if (par_cnt - p0 !== 0) begin errors++; $display("FAIL par_next_noerr: got %0d want 0", par_cnt - p0); end
  endtask

  task automatic test_break();
    int t0, p0, f0, r0;
    p0 = par_cnt; f0 = frm_cnt; r0 = rise_cnt;
    send_frame(8'h55, 1'b0, 1'b0, t0);
    repeat (100) tick();
    checks++; if (frm_cnt - f0 !== 1) begin errors++; $display("FAIL brk_frm: got %0d want 1", frm_cnt - f0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy_low: got %0b want 1", busy); end
    bus_in = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy_h1: got %0b want 1", busy); end
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy_h2: got %0b want 1", busy); end
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_busy_h3: got %0b want 0", busy); end
    @(posedge clk); #1;
    repeat (5) tick();
    checks++; if (frm_cnt - f0 !== 1) begin errors++; $display("FAIL brk_one_frm: got %0d want 1", frm_cnt - f0); end
    checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL brk_novalid: got %0d want 0", rise_cnt - r0); end
    checks++; if (par_cnt - p0 !== 0) begin errors++; $display("FAIL brk_nopar: got %0d want 0", par_cnt - p0); end
  endtask

  task automatic test_overrun();
    int t0, p0, f0, o0, r0, a0;
    p0 = par_cnt; f0 = frm_cnt; o0 = ovr_cnt; r0 = rise_cnt; a0 = acc_q.size();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, t0);
    send_frame(8'h22, 1'b0, 1'b1, t0);
    bus_in = 1'b1;
    repeat (10) tick();
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL ovr_rise: got %0d want 1", rise_cnt - r0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %0b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data: got %0h want 11", rx_data); end
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0); end
    checks++; if ((par_cnt - p0) + (frm_cnt - f0) !== 0) begin errors++; $display("FAIL ovr_other: got %0d want 0", (par_cnt - p0) + (frm_cnt - f0)); end
    rx_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop: got %0b want 0", rx_valid); end
    checks++; if (acc_q.size() - a0 !== 1) begin errors++; $display("FAIL ovr_acc_n: got %0d want 1", acc_q.size() - a0); end
    else begin
      checks++; if (acc_q[a0] !== 8'h11) begin errors++; $display("FAIL ovr_acc_data: got %0h want 11", acc_q[a0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int t0, o0, r0, d0, a0;
    o0 = ovr_cnt; r0 = rise_cnt; d0 = drop_cnt; a0 = acc_q.size();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, t0);
    send_frame(8'h22, 1'b0, 1'b1, t0);
    // Ready is high only for the cycle in which 0x22 is delivered.
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat (5) tick();
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL b2b_rise: got %0d want 1", rise_cnt - r0); end
    checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL b2b_nodrop: got %0d want 0", drop_cnt - d0); end
    checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL b2b_noovr: got %0d want 0", ovr_cnt - o0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL b2b_data: got %0h want 22", rx_data); end
    checks++; if (acc_q.size() - a0 !== 1) begin errors++; $display("FAIL b2b_acc_n: got %0d want 1", acc_q.size() - a0); end
    else begin
      checks++; if (acc_q[a0] !== 8'h11) begin errors++; $display("FAIL b2b_acc_data: got %0h want 11", acc_q[a0]); end
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_consume: got %0b want 0", rx_valid); end
  endtask

  task automatic test_glitch_reset();
    int t0, p0, f0, o0, r0;
    p0 = par_cnt; f0 = frm_cnt; o0 = ovr_cnt; r0 = rise_cnt;
    rx_ready = 1'b1;
    bus_in = 1'b0;
    tick();
    bus_in = 1'b1;
    repeat (10) tick();
    // Released line: the pull-up holds it high.
    repeat (20) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %0b want 0", busy); end
    checks++; if ((par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0) + (rise_cnt - r0) !== 0) begin errors++; $display("FAIL glitch_events: got %0d want 0", (par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0) + (rise_cnt - r0)); end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b want 1", busy); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({rx_valid, par_err, frm_err, ovr_err, busy} !== 5'b00000) begin errors++; $display("FAIL rst_async_outs: got %b want 00000", {rx_valid, par_err, frm_err, ovr_err, busy}); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_async_data: got %0h want 0", rx_data); end
    repeat (3) tick();
    rst = 1'b1;
    repeat (60) tick();
    checks++; if ((par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0) + (rise_cnt - r0) !== 0) begin errors++; $display("FAIL rst_events: got %0d want 0", (par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0) + (rise_cnt - r0)); end
    send_frame(8'h80, 1'b1, 1'b1, t0);
    bus_in = 1'b1;
    repeat (10) tick();
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL post_rst_rise: got %0d want 1", rise_cnt - r0); end
    checks++; if (rise_data !== 8'h80) begin errors++; $display("FAIL post_rst_data: got %0h want 80", rise_data); end
    checks++; if ((par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0) !== 0) begin errors++; $display("FAIL post_rst_errs: got %0d want 0", (par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0)); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_break();
    test_overrun();
    test_back_to_back();
    test_glitch_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
